// File: rtl/i2c_slave_pkg.sv
// Purpose : shared types and sizing helpers for the I2C slave frame timer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package i2c_slave_pkg;

   // Frame sequencer states; the encoding is internal to the timer.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PREP,
      ST_CHECK,
      ST_DONE
   } frame_state_t;

   // Default width of the idle watchdog counter and its limit.
   localparam int TIMEOUT_W_DEF = 16;

   // Bit-counter width: must hold every value 0..data_bits.
   function automatic int cnt_width(input int data_bits);
      return $clog2(data_bits + 1);
   endfunction

endpackage

// File: rtl/i2c_bus_watchdog.sv
// Purpose : bus-idle watchdog; counts enabled cycles since the last clear.
// Latency : expire is combinational from the count register.
// Backpressure: en low freezes the count (SCL stretch is not idleness).
module i2c_bus_watchdog #(
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic [TIMEOUT_W-1:0] limit,
   output logic                 expire
);

   logic [TIMEOUT_W-1:0] cnt_q;

   // Idle counter: cleared on activity, saturates at all-ones so it never wraps back under the limit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A zero limit disables the watchdog entirely.
   assign expire = (limit != '0) && (cnt_q >= limit);

endmodule

// File: rtl/i2c_slave_frame_timer.sv
// Purpose : I2C slave frame sequencer: counts SCL data bits between START/STOP and walks the ACK slot.
// Latency : state register then output register, so every flag moves 2 clk after its triggering pulse.
// Backpressure: stretch_req in ACK prep drives hold_scl and ignores SCL rising edges until released.
module i2c_slave_frame_timer
   import i2c_slave_pkg::*;
#(
   parameter  int DATA_BITS = 8,
   parameter  int TIMEOUT_W = TIMEOUT_W_DEF,
   localparam int CNT_W     = cnt_width(DATA_BITS)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 rising_edge,
   input  logic                 falling_edge,
   input  logic                 stretch_req,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   output logic                 byte_received,
   output logic                 ack_prep,
   output logic                 ack_check,
   output logic                 ack_done,
   output logic                 bit_strobe,
   output logic [CNT_W-1:0]     bit_index,
   output logic                 hold_scl,
   output logic                 busy,
   output logic                 bus_timeout
);

   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS);
   localparam logic [CNT_W-1:0] FIRST_BIT = CNT_W'(1);

   frame_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc_d, inc_q;
   logic             wd_clr, wd_expire, abort;

   // Expiry loses to start/stop arriving in the same cycle.
   assign abort  = wd_expire && (state_q != ST_IDLE) && !start && !stop;
   assign wd_clr = (state_q == ST_IDLE) || start || stop || rising_edge || falling_edge || abort;

   i2c_bus_watchdog #(
      .TIMEOUT_W(TIMEOUT_W)
   ) u_watchdog (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (wd_clr),
      .en    (!hold_scl),
      .limit (timeout_limit),
      .expire(wd_expire)
   );

   // Next state: stop, then start, then watchdog, then SCL edges (rising wins over falling).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inc_d   = 1'b0;
      if (stop && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (start) begin
         state_d = ST_START;
         cnt_d   = '0;
      end else if (abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_START, ST_DONE: begin
               if (rising_edge) begin
                  state_d = ST_DATA;
                  cnt_d   = FIRST_BIT;
                  inc_d   = 1'b1;
               end
            end
            ST_DATA: begin
               if (rising_edge) begin
                  if (cnt_q < LAST_BIT) begin
                     cnt_d = cnt_q + 1'b1;
                     inc_d = 1'b1;
                  end
               end else if (falling_edge && (cnt_q == LAST_BIT)) begin
                  state_d = ST_PREP;
                  cnt_d   = '0;
               end
            end
            ST_PREP: begin
               if (rising_edge && !stretch_req) begin
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (falling_edge && !rising_edge) begin
                  state_d = ST_DONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State, bit counter and increment marker registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         inc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inc_q   <= inc_d;
      end
   end

   // Registered output decode of the current state/counter.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         byte_received <= 1'b0;
         ack_prep      <= 1'b0;
         ack_check     <= 1'b0;
         ack_done      <= 1'b0;
         bit_strobe    <= 1'b0;
         bit_index     <= '0;
         hold_scl      <= 1'b0;
         busy          <= 1'b0;
         bus_timeout   <= 1'b0;
      end else begin
         byte_received <= (state_q == ST_PREP) || (state_q == ST_CHECK);
         ack_prep      <= (state_q == ST_PREP);
         ack_check     <= (state_q == ST_CHECK);
         ack_done      <= (state_q == ST_DONE);
         bit_strobe    <= inc_q;
         bit_index     <= cnt_q;
         hold_scl      <= (state_q == ST_PREP) && stretch_req;
         busy          <= (state_q != ST_IDLE);
         bus_timeout   <= abort;
      end
   end

endmodule
